// File: rtl/decode_ctrl_pipe.sv
// Instruction decode into a DEPTH-deep registered control pipeline with load-use stall and halt drain.
// Latency: 1 cycle into stage 0, one more per stage. Backpressure: combinational stall holds upstream PC and IF/ID.
// Optional ILLEGAL_TRAP_EN: flags illegal instructions on the illegal output and halts on them.
module decode_ctrl_pipe #(
    parameter int DEPTH = 3,
    parameter int RA_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    id_valid,
    input  logic [6:0]              opCode,
    input  logic [2:0]              funct3,
    input  logic [6:0]              funct7,
    input  logic [RA_W-1:0]         id_rs1,
    input  logic [RA_W-1:0]         id_rs2,
    input  logic [RA_W-1:0]         id_rd,
    input  logic                    flush,
    output logic [13*DEPTH-1:0]     ctrl_pipe,
    output logic [RA_W*DEPTH-1:0]   rd_pipe,
    output logic                    stall,
    output logic                    halted,
    output logic                    illegal
);

    localparam int CW    = 13;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CW-1:0]      ctrl_q [DEPTH];
    logic [RA_W-1:0]    rd_q   [DEPTH];
    logic [CW-1:0]      ctrl_d;
    logic [RA_W-1:0]    rd_d;

    logic               rw, m2r, mw, sb, lh, ld, jr;
    logic [1:0]         src;
    logic [3:0]         alu;
    logic               dec_legal, dec_halt;
    logic [CW-1:0]      dec_word;
    logic               accept, load, trap_hit, go_drain;

    always_comb begin
        rw = 1'b0; m2r = 1'b0; mw = 1'b0; src = 2'd0; alu = 4'd0;
        sb = 1'b0; lh = 1'b0; ld = 1'b0; jr = 1'b0;
        dec_legal = 1'b1;
        dec_halt  = 1'b0;
        case (opCode)
            7'h33: begin
                rw = 1'b1; m2r = 1'b1;
                case ({funct3, funct7})
                    {3'd1, 7'h20}: alu = 4'd1;
                    {3'd6, 7'h00}: alu = 4'd2;
                    {3'd7, 7'h00}: alu = 4'd3;
                    {3'd5, 7'h00}: alu = 4'd4;
                    {3'd4, 7'h00}: alu = 4'd5;
                    {3'd2, 7'h00}: alu = 4'd6;
                    {3'd3, 7'h00}: alu = 4'd7;
                    {3'd0, 7'h00}: alu = 4'd8;
                    default:       dec_legal = 1'b0;
                endcase
            end
            7'h13: begin
                rw = 1'b1; m2r = 1'b1; src = 2'd1;
                if (funct3 == 3'd0)      alu = 4'd1;
                else if (funct3 == 3'd7) alu = 4'd4;
                else                     dec_legal = 1'b0;
            end
            7'h1B: begin
                rw = 1'b1; m2r = 1'b1; src = 2'd1; alu = 4'd3;
                if (funct3 != 3'd6) dec_legal = 1'b0;
            end
            7'h67: begin
                rw = 1'b1; m2r = 1'b1; src = 2'd2; alu = 4'd9; jr = 1'b1;
            end
            7'h03: begin
                rw = 1'b1; src = 2'd1; alu = 4'd1; ld = 1'b1;
                lh = (funct3 == 3'd2);
            end
            7'h63: alu = 4'd2;
            7'h6F: begin
                rw = 1'b1; m2r = 1'b1; src = 2'd2; alu = 4'd9;
            end
            7'h38: begin
                rw = 1'b1; m2r = 1'b1; src = 2'd1; alu = 4'd10;
            end
            7'h23: begin
                mw = 1'b1; src = 2'd1; alu = 4'd1;
                sb = (funct3 == 3'd0);
            end
            7'h7F:   dec_halt  = 1'b1;
            default: dec_legal = 1'b0;
        endcase
        dec_word = {rw, m2r, mw, src, alu, sb, lh, ld, jr};
    end

    // Stage-0 rd is already zero for bubbles, so rd!=0 also excludes empty slots.
    assign stall = (state_q == RUN) && id_valid && !flush && ctrl_q[0][1] &&
                   (rd_q[0] != '0) && ((rd_q[0] == id_rs1) || (rd_q[0] == id_rs2));

    assign accept = (state_q == RUN) && id_valid && !flush && !stall;
    assign load   = accept && dec_legal && !dec_halt;
    assign ctrl_d = load ? dec_word : '0;
    assign rd_d   = load ? id_rd : '0;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    assign trap_hit = accept && !dec_legal;
    assign illegal  = illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) illegal_q <= 1'b0;
        else          illegal_q <= trap_hit;
    end
`else
    assign trap_hit = 1'b0;
    assign illegal  = 1'b0;
`endif

    assign go_drain = accept && (dec_halt || trap_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_q[k] <= '0;
                rd_q[k]   <= '0;
            end
        end else begin
            ctrl_q[0] <= ctrl_d;
            rd_q[0]   <= rd_d;
            for (int k = 1; k < DEPTH; k++) begin
                ctrl_q[k] <= ctrl_q[k-1];
                rd_q[k]   <= rd_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (go_drain) begin
                        state_q <= DRAIN;
                        cnt_q   <= CNT_W'(DEPTH);
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) state_q <= HALTED;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: state_q <= HALTED;
            endcase
        end
    end

    always_comb begin
        ctrl_pipe = '0;
        rd_pipe   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ctrl_pipe[CW*k +: CW]     = ctrl_q[k];
            rd_pipe[RA_W*k +: RA_W]   = rd_q[k];
        end
    end

    assign halted = (state_q == HALTED) && (ctrl_pipe == '0);

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe (DEPTH=3, RA_W=5): decode table plus stall, flush, halt and reset sequences.
module tb_decode_ctrl_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [6:0]  opCode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        flush;
    logic [38:0] ctrl_pipe;
    logic [14:0] rd_pipe;
    logic        stall, halted, illegal;

    int checks = 0;
    int errors = 0;

    decode_ctrl_pipe #(.DEPTH(3), .RA_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .opCode(opCode),
        .funct3(funct3), .funct7(funct7), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .flush(flush), .ctrl_pipe(ctrl_pipe), .rd_pipe(rd_pipe),
        .stall(stall), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        fl;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [12:0] exp_word;
        logic [4:0]  exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
        id_valid = v; flush = f; opCode = op; funct3 = f3; funct7 = f7;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        idle();
        #3;
        chk("reset_ctrl", 64'(ctrl_pipe), 64'h0);
        chk("reset_rd", 64'(rd_pipe), 64'h0);
        chk("reset_halted", 64'(halted), 64'h0);
        chk("reset_illegal", 64'(illegal), 64'h0);
        chk("reset_stall", 64'(stall), 64'h0);
        #9;
        reset_n = 1'b1;

        vecs.push_back('{1'b1, 1'b0, 7'h33, 3'd1, 7'h20, 5'd3,  13'h1810, 5'd3});
        vecs.push_back('{1'b1, 1'b0, 7'h33, 3'd6, 7'h00, 5'd4,  13'h1820, 5'd4});
        vecs.push_back('{1'b1, 1'b0, 7'h33, 3'd7, 7'h00, 5'd5,  13'h1830, 5'd5});
        vecs.push_back('{1'b1, 1'b0, 7'h33, 3'd5, 7'h00, 5'd6,  13'h1840, 5'd6});
        vecs.push_back('{1'b1, 1'b0, 7'h33, 3'd4, 7'h00, 5'd7,  13'h1850, 5'd7});
        vecs.push_back('{1'b1, 1'b0, 7'h33, 3'd2, 7'h00, 5'd8,  13'h1860, 5'd8});
        vecs.push_back('{1'b1, 1'b0, 7'h33, 3'd3, 7'h00, 5'd9,  13'h1870, 5'd9});
        vecs.push_back('{1'b1, 1'b0, 7'h33, 3'd0, 7'h00, 5'd10, 13'h1880, 5'd10});
        vecs.push_back('{1'b1, 1'b0, 7'h13, 3'd0, 7'h00, 5'd11, 13'h1910, 5'd11});
        vecs.push_back('{1'b1, 1'b0, 7'h1B, 3'd6, 7'h00, 5'd12, 13'h1930, 5'd12});
        vecs.push_back('{1'b1, 1'b0, 7'h13, 3'd7, 7'h00, 5'd13, 13'h1940, 5'd13});
        vecs.push_back('{1'b1, 1'b0, 7'h67, 3'd0, 7'h00, 5'd1,  13'h1A91, 5'd1});
        vecs.push_back('{1'b1, 1'b0, 7'h03, 3'd2, 7'h00, 5'd14, 13'h1116, 5'd14});
        vecs.push_back('{1'b1, 1'b0, 7'h03, 3'd0, 7'h00, 5'd15, 13'h1112, 5'd15});
        vecs.push_back('{1'b1, 1'b0, 7'h63, 3'd0, 7'h00, 5'd16, 13'h0020, 5'd16});
        vecs.push_back('{1'b1, 1'b0, 7'h6F, 3'd0, 7'h00, 5'd17, 13'h1A90, 5'd17});
        vecs.push_back('{1'b1, 1'b0, 7'h38, 3'd0, 7'h00, 5'd18, 13'h19A0, 5'd18});
        vecs.push_back('{1'b1, 1'b0, 7'h23, 3'd0, 7'h00, 5'd19, 13'h0518, 5'd19});
        vecs.push_back('{1'b1, 1'b0, 7'h23, 3'd2, 7'h00, 5'd20, 13'h0510, 5'd20});
        vecs.push_back('{1'b0, 1'b0, 7'h33, 3'd1, 7'h20, 5'd21, 13'h0000, 5'd0});
        vecs.push_back('{1'b1, 1'b1, 7'h33, 3'd1, 7'h20, 5'd22, 13'h0000, 5'd0});
`ifndef ILLEGAL_TRAP_EN
        vecs.push_back('{1'b1, 1'b0, 7'h33, 3'd1, 7'h00, 5'd23, 13'h0000, 5'd0});
        vecs.push_back('{1'b1, 1'b0, 7'h13, 3'd1, 7'h00, 5'd24, 13'h0000, 5'd0});
        vecs.push_back('{1'b1, 1'b0, 7'h1B, 3'd0, 7'h00, 5'd25, 13'h0000, 5'd0});
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].fl, vecs[i].op, vecs[i].f3, vecs[i].f7, 5'd0, 5'd0, vecs[i].rd);
            #1;
            chk($sformatf("vec%0d_stall", i), 64'(stall), 64'h0);
            tick();
            chk($sformatf("vec%0d_word", i), 64'(ctrl_pipe[12:0]), 64'(vecs[i].exp_word));
            chk($sformatf("vec%0d_rd", i), 64'(rd_pipe[4:0]), 64'(vecs[i].exp_rd));
        end
        idle();
        repeat (3) tick();

        // add travels through all three stages, one per edge
        drive(1'b1, 1'b0, 7'h33, 3'd1, 7'h20, 5'd1, 5'd2, 5'd3);
        tick();
        idle();
        chk("lat_s0", 64'(ctrl_pipe[12:0]), 64'h1810);
        tick();
        chk("lat_s1", 64'(ctrl_pipe[25:13]), 64'h1810);
        chk("lat_s1_rd", 64'(rd_pipe[9:5]), 64'd3);
        tick();
        chk("lat_s2", 64'(ctrl_pipe[38:26]), 64'h1810);
        chk("lat_s2_rd", 64'(rd_pipe[14:10]), 64'd3);
        tick();
        chk("lat_s2_clear", 64'(ctrl_pipe[38:26]), 64'h0);

        // load-use: lh x5 then add rs1=5
        drive(1'b1, 1'b0, 7'h03, 3'd2, 7'h00, 5'd0, 5'd0, 5'd5);
        tick();
        chk("lu_lh_word", 64'(ctrl_pipe[12:0]), 64'h1116);
        drive(1'b1, 1'b0, 7'h33, 3'd1, 7'h20, 5'd5, 5'd0, 5'd3);
        #1;
        chk("lu_stall_hi", 64'(stall), 64'h1);
        tick();
        chk("lu_bubble", 64'(ctrl_pipe[12:0]), 64'h0);
        chk("lu_bubble_rd", 64'(rd_pipe[4:0]), 64'h0);
        chk("lu_stall_lo", 64'(stall), 64'h0);
        chk("lu_lh_s1", 64'(ctrl_pipe[25:13]), 64'h1116);
        tick();
        chk("lu_add_in", 64'(ctrl_pipe[12:0]), 64'h1810);

        // rs2 match also stalls; flush overrides it
        drive(1'b1, 1'b0, 7'h03, 3'd0, 7'h00, 5'd0, 5'd0, 5'd6);
        tick();
        drive(1'b1, 1'b0, 7'h33, 3'd1, 7'h20, 5'd0, 5'd6, 5'd3);
        #1;
        chk("lu_rs2_stall", 64'(stall), 64'h1);
        flush = 1'b1;
        #1;
        chk("flush_stall", 64'(stall), 64'h0);
        tick();
        chk("flush_bubble", 64'(ctrl_pipe[12:0]), 64'h0);
        idle();
        repeat (3) tick();

        // illegal opcode 0x7B
        drive(1'b1, 1'b0, 7'h7B, 3'd0, 7'h00, 5'd0, 5'd0, 5'd4);
        tick();
        idle();
        chk("ill_bubble", 64'(ctrl_pipe[12:0]), 64'h0);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_pulse", 64'(illegal), 64'h1);
        tick();
        chk("ill_pulse_end", 64'(illegal), 64'h0);
        chk("ill_not_yet", 64'(halted), 64'h0);
        repeat (3) tick();
        chk("ill_halted", 64'(halted), 64'h1);
`else
        chk("ill_flag", 64'(illegal), 64'h0);
        repeat (5) tick();
        chk("ill_no_halt", 64'(halted), 64'h0);
`endif
        do_reset();

        // halt drains in DEPTH+1 edges
        drive(1'b1, 1'b0, 7'h33, 3'd0, 7'h00, 5'd0, 5'd0, 5'd9);
        tick();
        drive(1'b1, 1'b0, 7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd2);
        tick();
        idle();
        chk("halt_bubble", 64'(ctrl_pipe[12:0]), 64'h0);
        chk("halt_s1_add", 64'(ctrl_pipe[25:13]), 64'h1880);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("halt_e%0d", e), 64'(halted), 64'h0);
        end
        tick();
        chk("halt_e4", 64'(halted), 64'h1);
        chk("halt_pipe_zero", 64'(ctrl_pipe), 64'h0);
        drive(1'b1, 1'b0, 7'h03, 3'd0, 7'h00, 5'd0, 5'd0, 5'd7);
        #1;
        chk("halted_no_stall", 64'(stall), 64'h0);
        tick();
        chk("halted_ignores", 64'(ctrl_pipe[12:0]), 64'h0);
        chk("halted_stays", 64'(halted), 64'h1);
        do_reset();

        // reset in the middle of a drain
        drive(1'b1, 1'b0, 7'h33, 3'd1, 7'h20, 5'd0, 5'd0, 5'd3);
        tick();
        drive(1'b1, 1'b0, 7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0);
        tick();
        idle();
        tick();
        chk("mid_pipe_busy", 64'(ctrl_pipe[38:26]), 64'h1810);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 64'(ctrl_pipe), 64'h0);
        chk("mid_rst_rd", 64'(rd_pipe), 64'h0);
        chk("mid_rst_halted", 64'(halted), 64'h0);
        chk("mid_rst_illegal", 64'(illegal), 64'h0);
        #1;
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 7'h23, 3'd2, 7'h00, 5'd0, 5'd0, 5'd6);
        tick();
        idle();
        chk("sw_word", 64'(ctrl_pipe[12:0]), 64'h0510);
        chk("sw_rd", 64'(rd_pipe[4:0]), 64'd6);
        repeat (6) tick();
        chk("mid_rst_no_halt", 64'(halted), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 3, number of registered control stages after decode (1..4).
REQ-002 SHALL have parameter RA_W, default 5, register-address width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_valid  input  1  ID-stage instruction present.
REQ-006 SHALL have port opCode / funct3 / funct7  input  7/3/7  instruction fields in ID.
REQ-007 SHALL have port id_rs1 / id_rs2 / id_rd  input  RA_W each  ID register addresses.
REQ-008 SHALL have port flush  input  1  branch/jump redirect; kills the ID instruction.
REQ-009 SHALL have port ctrl_pipe  output  13*DEPTH  stage k control word at bits [13k+12:13k], k=0 nearest decode.
REQ-010 SHALL have port rd_pipe  output  RA_W*DEPTH  destination address per stage.
REQ-011 SHALL have port stall  output  1  combinational load-use stall; upstream holds PC and IF/ID.
REQ-012 SHALL have port halted  output  1  pipeline drained after halt.
REQ-013 SHALL have port illegal  output  1  registered illegal-instruction flag (only with ILLEGAL_TRAP_EN).

Function
REQ-014 SHALL pack each control word as {regWrite, memtoReg, memWrite, ALUsrc[1:0], ALUop[3:0], sb, lh, ld, jalr}, MSB first.
REQ-015 SHALL decode: 0x33 R-type, ALUop by {funct3,funct7}: {1,0x20}=add 1, {6,0}=sub 2, {7,0}=and 3, {5,0}=or 4, {4,0}=sll 5, {2,0}=srl 6, {3,0}=xor 7, {0,0}=slt 8; regWrite=memtoReg=1, ALUsrc=0.
REQ-016 SHALL decode I/other types: 0x13/f3=0 addi (add, src 1); 0x1B/f3=6 andi (and, src 1); 0x13/f3=7 ori (or, src 1); 0x67 jalr (ALUop 9, src 2, jalr=1); 0x03 load (add, src 1, ld=1, memtoReg=0, lh=(f3==2)); 0x63 branch (sub, src 0, regWrite=0); 0x6F jal (ALUop 9, src 2); 0x38 lui (ALUop 10, src 1); 0x23 store (add, src 1, memWrite=1, regWrite=0, sb=(f3==0)).
REQ-017 SHALL treat any other opCode/funct combination, except halt 0x7F, as illegal, producing an all-zero word (bubble).
REQ-018 SHALL register the decoded word into stage 0 each cycle; stage k SHALL take stage k-1 each cycle, with no enable on stages >=1.
REQ-019 SHALL register id_rd into rd_pipe alongside each word, forcing 0 whenever the word is a bubble.
REQ-020 SHALL assert stall when id_valid, stage-0 ld=1, stage-0 rd!=0, and (stage-0 rd==id_rs1 or ==id_rs2).
REQ-021 SHALL load a bubble into stage 0 on any cycle where stall, flush, !id_valid, or state!=RUN holds.
REQ-022 SHALL give flush priority over stall: stall is deasserted in a flush cycle.
REQ-023 SHALL implement FSM RUN -> DRAIN on a valid, unflushed, unstalled 0x7F; a halt in ID itself loads a bubble.
REQ-024 SHALL hold a DRAIN counter loaded with DEPTH and decremented per cycle, moving DRAIN -> HALTED when it reaches 0 on the next edge; HALTED exits only on reset.
REQ-025 SHALL assert halted only in HALTED, when all stages contain bubbles; stall SHALL be 0 outside RUN.

Reset
REQ-026 SHALL, on reset_n low and independently of clk, clear all stages and rd_pipe to 0, set the FSM to RUN, clear the drain counter, and drive halted=0 and illegal=0.
REQ-027 SHALL let reset mid-DRAIN abandon the drain, with the first decode on the first rising edge after release.

Configuration
REQ-028 SHALL, with ILLEGAL_TRAP_EN defined, register illegal=1 for one cycle for each illegal instruction that would otherwise enter stage 0 (valid, not flushed, not stalled, state RUN), and treat it as a halt (RUN -> DRAIN).
REQ-029 SHALL, without ILLEGAL_TRAP_EN, tie illegal to 0 and insert illegal instructions silently as bubbles.

Verification
REQ-030 SHALL pass: add x3 (0x33,f3=1,f7=0x20) -> stage0 word regWrite=1,memtoReg=1,ALUop=1 one cycle later, at stage2 three cycles after the edge (DEPTH=3).
REQ-031 SHALL pass: lh x5 then add using rs1=5 -> stall=1 one cycle, stage0 bubble, add enters next cycle, lh word has ld=1 and lh=1.
REQ-032 SHALL pass: flush=1 together with load-use condition -> stall=0 and stage0 bubble.
REQ-033 SHALL pass: 0x7F with DEPTH=3 -> halted=1 exactly 4 edges after the halt edge, and all ctrl_pipe=0.
REQ-034 SHALL pass: opCode 0x7B with ILLEGAL_TRAP_EN -> illegal pulses 1 cycle, then halted; without the macro -> bubble, no halt.
REQ-035 SHALL pass: reset_n low mid-DRAIN -> outputs zero immediately, and a following sw (0x23,f3=2) decodes memWrite=1, sb=0.
